// File: rtl/get_module.sv
// get_module: read-side stream controller. Pops words from the input FIFO,
// which returns data one cycle after the read strobe. Words are held in a
// two-entry prefetch buffer, and the core is strobed whenever an operand is
// buffered and the downstream side is not stalled.
module get_module #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  ENABLE,
  input  logic                  EMPTY,
  input  logic [DATA_WIDTH-1:0] FIFO_DOUT,
  input  logic                  HOLD,
  output logic                  FIFO_READ_EN,
  output logic                  ENABLE_CORE,
  output logic [DATA_WIDTH-1:0] CORE_DIN,
  output logic [CNT_WIDTH-1:0]  WORD_COUNT
);

  // The state encodes the buffer occupancy directly: BUF0, BUF1 or BUF2
  // means 0, 1 or 2 words held.
  typedef enum logic [1:0] {
    BUF0 = 2'd0,
    BUF1 = 2'd1,
    BUF2 = 2'd2
  } buf_state_e;

  buf_state_e            state_q, state_d;
  logic                  pend_q, pend_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic [CNT_WIDTH-1:0]  word_count_q, word_count_d;

  logic [1:0] count_w;  // words currently buffered
  logic [1:0] kept_w;   // words still buffered after this cycle's consume
  logic [2:0] fill_w;   // buffered plus in-flight words after this cycle's consume

  // Consume/issue strobes, the capture slot and the next state.
  always_comb begin
    state_d      = state_q;
    head_d       = head_q;
    tail_d       = tail_q;
    count_w      = state_q;

    ENABLE_CORE  = ENABLE & ~HOLD & (state_q != BUF0);

    // ENABLE_CORE can only be high when count_w >= 1, so this never wraps.
    kept_w       = count_w - {1'b0, ENABLE_CORE};
    fill_w       = {1'b0, kept_w} + {2'b00, pend_q};

    // A new read is issued only if the returning word is guaranteed a free
    // slot. The strobe is gated by RESET so that nothing is issued while the
    // buffer is being cleared.
    FIFO_READ_EN = ENABLE & ~EMPTY & ~RESET & (fill_w < 3'd2);
    pend_d       = FIFO_READ_EN;

    // On a consume, the tail shifts forward into the head.
    if (ENABLE_CORE) begin
      head_d = tail_q;
    end

    // A returning word goes into the first slot that is free after the
    // consume.
    if (pend_q) begin
      if (kept_w == 2'd0) begin
        head_d = FIFO_DOUT;
      end else begin
        tail_d = FIFO_DOUT;
      end
    end

    // Occupancy changes only when exactly one of capture or consume happens.
    unique case (state_q)
      BUF0: begin
        if (pend_q) state_d = BUF1;
      end
      BUF1: begin
        if (pend_q && !ENABLE_CORE)      state_d = BUF2;
        else if (!pend_q && ENABLE_CORE) state_d = BUF0;
      end
      BUF2: begin
        if (!pend_q && ENABLE_CORE) state_d = BUF1;
      end
      default: state_d = BUF0;
    endcase

    word_count_d = word_count_q + CNT_WIDTH'(ENABLE_CORE);
  end

  // State, buffer and counter registers. Reset discards any in-flight word.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= BUF0;
      pend_q       <= 1'b0;
      head_q       <= '0;
      tail_q       <= '0;
      word_count_q <= '0;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      head_q       <= head_d;
      tail_q       <= tail_d;
      word_count_q <= word_count_d;
    end
  end

  assign CORE_DIN   = head_q;
  assign WORD_COUNT = word_count_q;

endmodule

// File: doc/get_module.md
# get_module

Read-side stream controller for an IPPro core: the consuming counterpart of the FIFO-writing put controller. It pops words from the upstream input FIFO (standard mode, one-cycle read latency), buffers them in a two-entry prefetch register so the core sees no bubbles, and gates ENABLE_CORE so the core only advances when an operand is present and the downstream side is not stalled. It sits between the input FIFO's read port and the core's data input.

## Interface
- DATA_WIDTH, 16, FIFO/core data word width
- CNT_WIDTH, 16, width of the consumed-word counter
- CLK  in  1  system clock; all logic rising-edge
- RESET  in  1  synchronous, active-high reset
- ENABLE  in  1  stream enable from the control plane
- EMPTY  in  1  input FIFO empty flag
- FIFO_DOUT  in  DATA_WIDTH  input FIFO read data, valid the cycle after FIFO_READ_EN
- HOLD  in  1  downstream stall (output side cannot accept); blocks consumption
- FIFO_READ_EN  out  1  input FIFO read strobe
- ENABLE_CORE  out  1  core advance strobe; CORE_DIN consumed on this cycle's edge
- CORE_DIN  out  DATA_WIDTH  head of prefetch buffer
- WORD_COUNT  out  CNT_WIDTH  number of words consumed since reset

## Operation
- State: buffer occupancy COUNT (0, 1, 2; FSM states BUF0/BUF1/BUF2), in-flight flag PEND, two data entries (head, tail), WORD_COUNT register.
- Consume: ENABLE_CORE = ENABLE & ~HOLD & (COUNT != 0), combinational from registers and inputs. On consume, tail shifts to head.
- Issue: FIFO_READ_EN = ENABLE & ~EMPTY & ~RESET & ((COUNT + PEND − ENABLE_CORE) < 2). Guarantees buffer never overflows; never reads an empty FIFO.
- Capture: PEND <= FIFO_READ_EN. When PEND is 1, FIFO_DOUT written to the first free slot after accounting for this cycle's consume (head if buffer becomes empty, else tail).
- COUNT next = COUNT + PEND − ENABLE_CORE; transitions BUF0→BUF1 (capture only), BUF1→BUF2 (capture, no consume), BUF2→BUF1 (consume, no capture), BUF1→BUF0 (consume, no capture); capture+consume holds state.
- ENABLE low: no new reads, no consumption; buffered data retained; an already in-flight word is still captured. Resuming ENABLE continues without loss or duplication.
- HOLD high: consumption stops; reads continue until COUNT + PEND = 2, then FIFO_READ_EN drops.
- WORD_COUNT increments by 1 on each ENABLE_CORE cycle; wraps from 2^CNT_WIDTH−1 to 0.
- Reset mid-operation: buffer, PEND and WORD_COUNT cleared; an in-flight word is discarded (not captured).

## Timing
- Reset values: FIFO_READ_EN 0, ENABLE_CORE 0, CORE_DIN 0, WORD_COUNT 0, COUNT 0, PEND 0.
- Read-to-core latency 2: FIFO_READ_EN high in cycle t → FIFO_DOUT valid in t+1 → captured at end of t+1 → ENABLE_CORE high in t+2 with that word on CORE_DIN.
- Sustained throughput one word per cycle with FIFO non-empty and HOLD low (steady state COUNT=1, PEND=1).
- EMPTY asserted: FIFO_READ_EN low same cycle; core drains buffered words then ENABLE_CORE drops.
- HOLD deassert: ENABLE_CORE rises the same cycle if COUNT != 0.
- Simultaneous capture, consume and issue in one cycle is legal and required.

## Test plan
- Reset, then ENABLE=1, FIFO preloaded 1..8, HOLD=0 -> first FIFO_READ_EN in cycle 0, ENABLE_CORE from cycle 2 for 8 consecutive cycles, CORE_DIN = 1..8 in order, WORD_COUNT = 8.
- HOLD=1 from start with FIFO holding 5 words -> exactly 2 reads issued, COUNT=2, ENABLE_CORE never high; release HOLD -> 5 words delivered in order, no gaps once streaming.
- EMPTY toggles every other cycle during stream -> no read while EMPTY=1, data delivered in order, no duplicates or drops.
- ENABLE dropped for 3 cycles while PEND=1 -> in-flight word captured, no reads or ENABLE_CORE during gap, sequence resumes intact.
- RESET asserted for 1 cycle with COUNT=2, PEND=1 -> all outputs return to reset values next cycle; next delivered word is the FIFO word following the discarded one.
- CNT_WIDTH=4, consume 17 words -> WORD_COUNT wraps 15→0 and reads 1.
